ifu_fetch: RTL

Instruction fetch front end. Generates the sequential fetch PC, issues word reads on the instruction bus with up to `DEPTH` requests in flight, and buffers returned words in a `DEPTH`-entry response FIFO. It delivers {addr, inst} pairs to the IFU→BPU decoupling FIFO directly downstream, honouring that stage's `o_ifu_vld` back-pressure. On flush it redirects the PC and discards every stale in-flight or buffered word.

---
 rtl/ifu_fetch.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Generic synchronous FIFO with occupancy count and a same-cycle clear.
// Latency: a pushed word is visible at the head on the following cycle; there is no bypass path.
// Backpressure: none inside the FIFO; the owner must never push when full or pop when empty.
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_vld,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_vld)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_vld, pop_vld})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// Instruction fetch front end: sequential PC, credited ibus reads, in-order response buffer.
// Latency: grant at t with a 1-cycle bus delivers at t+2; a response at t is deliverable at t+1.
// Backpressure: delivery waits on i_ifu_vld; new requests stop while in-flight plus buffered words reach DEPTH.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ifu_vld,
    input  logic        i_flush,
    input  logic [31:0] i_flush_addr,
    output logic        o_ibus_req,
    output logic [31:0] o_ibus_addr,
    input  logic        i_ibus_gnt,
    input  logic        i_ibus_rvld,
    input  logic [31:0] i_ibus_rdata,
    output logic        o_data_vld,
    output logic [31:0] o_iaddr,
    output logic [31:0] o_data
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   LIMIT   = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = 1;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] inst;
    } resp_t;

    logic [29:0]   pc;
    logic [CW-1:0] outst;
    logic [CW-1:0] drop;
    logic [CW-1:0] cnt;
    logic [29:0]   aq_head;
    resp_t         resp_in;
    resp_t         resp_head;
    logic          issue;
    logic          rsp;
    logic          keep;
    logic          show;
    logic          unused_ok;

    assign o_ibus_req  = ~i_rst & ~i_flush & (({1'b0, outst} + {1'b0, cnt}) < LIMIT);
    assign o_ibus_addr = {pc, 2'b00};
    assign issue       = o_ibus_req & i_ibus_gnt;

    // A response with nothing outstanding is a bus protocol error and is dropped on the floor.
    assign rsp  = i_ibus_rvld & (outst != '0);
    assign keep = rsp & (drop == '0) & ~i_flush;

    assign resp_in = '{addr: aq_head, inst: i_ibus_rdata};

    assign o_data_vld = (cnt != '0) & i_ifu_vld & ~i_flush & ~i_rst;
    assign show       = (cnt != '0) & ~i_rst;
    assign o_iaddr    = show ? {resp_head.addr, 2'b00} : 32'h0000_0000;
    assign o_data     = show ? resp_head.inst : 32'h0000_0013;

    assign unused_ok = ^i_flush_addr[1:0];

    // Address queue never clears on flush: stale requests still return and must be popped.
    fifo #(.W(30), .DEPTH(DEPTH), .CW(CW)) u_addr_q (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (1'b0),
        .push_vld (issue),
        .push_dat (pc),
        .pop_vld  (rsp),
        .head_dat (aq_head),
        .cnt      (outst)
    );

    fifo #(.W($bits(resp_t)), .DEPTH(DEPTH), .CW(CW)) u_resp_q (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (i_flush),
        .push_vld (keep),
        .push_dat (resp_in),
        .pop_vld  (o_data_vld),
        .head_dat (resp_head),
        .cnt      (cnt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc   <= RESET_PC[31:2];
            drop <= '0;
        end else if (i_flush) begin
            pc   <= i_flush_addr[31:2];
            drop <= outst - {{(CW - 1){1'b0}}, rsp};
        end else begin
            if (issue) pc <= pc + 30'd1;
            if (rsp && (drop != '0)) drop <= drop - CNT_ONE;
        end
    end

    property p_no_orphan_rsp;
        @(posedge i_clk) disable iff (i_rst) i_ibus_rvld |-> (outst != '0);
    endproperty
    assert property (p_no_orphan_rsp);
endmodule
